// File: rtl/ipm_distributed_sync_fifo_v1_3.sv
//------------------------------------------------------------------------------
// ipm_distributed_sync_fifo_v1_3
//
// Single-clock FIFO built on distributed RAM (registered write, asynchronous
// read). Pointer, count and flag control live in this module. The FIFO
// supports either a standard registered read or a first-word-fall-through
// read, runtime almost-full/almost-empty thresholds, a synchronous flush and
// one-cycle overflow/underflow error pulses. It sits in front of the DDR3
// controller command/data paths where producer and consumer share one clock.
//
// Parameters
//   ADDR_WIDTH   depth = 2**ADDR_WIDTH entries, every entry usable (4..10)
//   DATA_WIDTH   width of one entry (1..256)
//   FWFT_MODE    0 = rd_data valid the cycle after rd_en
//                1 = head word presented combinationally while not empty
//
// Ports
//   clk           single clock, rising edge
//   rst_n         asynchronous active-low reset
//   clr           synchronous flush, active-high, wins over wr_en/rd_en
//   wr_data       write data
//   wr_en         write request
//   full          FIFO holds 2**ADDR_WIDTH entries
//   almost_full   water_level >= af_level
//   overflow      one-cycle pulse: write attempted while full
//   rd_data       read data
//   rd_en         read request (pop)
//   empty         FIFO holds no entries
//   almost_empty  water_level <= ae_level
//   underflow     one-cycle pulse: read attempted while empty
//   af_level      almost-full threshold, quasi-static
//   ae_level      almost-empty threshold, quasi-static
//   water_level   current occupancy
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module ipm_distributed_sync_fifo_v1_3 #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FWFT_MODE  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_en,
    output logic                  empty,
    output logic                  almost_empty,
    output logic                  underflow,
    input  logic [ADDR_WIDTH:0]   af_level,
    input  logic [ADDR_WIDTH:0]   ae_level,
    output logic [ADDR_WIDTH:0]   water_level
);

    localparam int                DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    // Storage and control state
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic                  r_ready;
    logic [ADDR_WIDTH-1:0] r_wrPtr;
    logic [ADDR_WIDTH-1:0] r_rdPtr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_almostFull;
    logic                  r_almostEmpty;
    logic                  r_overflow;
    logic                  r_underflow;

    // Combinational helpers
    logic                  w_wrAcc;
    logic                  w_rdAcc;
    logic [ADDR_WIDTH:0]   w_countNext;
    logic [DATA_WIDTH-1:0] w_memRdWord;

    // Reset release is retimed through one flop so that the deassertion of
    // rst_n never races the first write: the edge that sees rst_n rise only
    // sets r_ready, and the following edge is the first one that may accept
    // a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b1;
        end
    end

    // Full and empty block their own side regardless of what the other side
    // does in the same cycle; a flush blocks both sides.
    assign w_wrAcc = wr_en & ~r_full  & ~clr & r_ready;
    assign w_rdAcc = rd_en & ~r_empty & ~clr;

    // Next occupancy; a simultaneous accepted write and read cancel out.
    always_comb begin
        w_countNext = r_count;
        if (clr) begin
            w_countNext = '0;
        end else begin
            w_countNext = r_count + (ADDR_WIDTH + 1)'(w_wrAcc)
                                  - (ADDR_WIDTH + 1)'(w_rdAcc);
        end
    end

    // Distributed RAM: registered write, asynchronous read at the read
    // pointer. Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wrAcc) begin
            r_mem[r_wrPtr] <= wr_data;
        end
    end

    assign w_memRdWord = r_mem[r_rdPtr];

    // Pointers, occupancy and every flag are registered from the next count,
    // so flags change on the same edge as the count with no extra latency.
    // Thresholds are sampled every cycle, so a threshold change shows up on
    // the next edge even when the occupancy does not move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
            r_count       <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_almostFull  <= 1'b0;
            r_almostEmpty <= 1'b1;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            if (clr) begin
                r_wrPtr <= '0;
                r_rdPtr <= '0;
            end else begin
                if (w_wrAcc) begin
                    r_wrPtr <= r_wrPtr + ADDR_WIDTH'(1);
                end
                if (w_rdAcc) begin
                    r_rdPtr <= r_rdPtr + ADDR_WIDTH'(1);
                end
            end
            r_count       <= w_countNext;
            r_full        <= (w_countNext == C_DEPTH);
            r_empty       <= (w_countNext == '0);
            r_almostFull  <= (w_countNext >= af_level);
            r_almostEmpty <= (w_countNext <= ae_level);
            r_overflow    <= wr_en & r_full  & ~clr;
            r_underflow   <= rd_en & r_empty & ~clr;
        end
    end

    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almostFull;
    assign almost_empty = r_almostEmpty;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    assign water_level  = r_count;

    generate
        if (FWFT_MODE != 0) begin : g_fwft
            // The head entry is already sitting at the read pointer, so it is
            // presented straight out of the RAM; rd_en only advances the
            // pointer. Zero is driven while empty so that reset shows a clean
            // bus.
            assign rd_data = r_empty ? '0 : w_memRdWord;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_rdData;

            // Standard read: capture the head entry on an accepted pop and
            // hold it otherwise, including through an underflow. A flush
            // clears the output register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rdData <= '0;
                end else if (clr) begin
                    r_rdData <= '0;
                end else if (w_rdAcc) begin
                    r_rdData <= w_memRdWord;
                end
            end

            assign rd_data = r_rdData;
        end
    endgenerate

    // Structural invariants of the pointer/count bookkeeping.
    a_fullEmptyExclusive : assert property (
        @(posedge clk) disable iff (!rst_n) !(r_full && r_empty));

    a_countInRange : assert property (
        @(posedge clk) disable iff (!rst_n) r_count <= C_DEPTH);

    a_ptrDiffMatchesCount : assert property (
        @(posedge clk) disable iff (!rst_n)
        (r_wrPtr - r_rdPtr) == r_count[ADDR_WIDTH-1:0]);

    a_flagsMatchCount : assert property (
        @(posedge clk) disable iff (!rst_n)
        (r_full == (r_count == C_DEPTH)) && (r_empty == (r_count == '0)));

endmodule

// File: tb/tb_ipm_distributed_sync_fifo_v1_3.sv
//------------------------------------------------------------------------------
// tb_ipm_distributed_sync_fifo_v1_3
//
// Drives one standard-mode and one FWFT-mode FIFO (ADDR_WIDTH=4,
// DATA_WIDTH=32) with identical directed stimulus. Each stimulus cycle
// updates a small reference model and pushes the expected post-edge outputs
// into a queue; an independent monitor pops one entry per edge and compares.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ipm_distributed_sync_fifo_v1_3;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    typedef struct {
        logic [AW:0]   level;
        logic          full;
        logic          empty;
        logic          af;
        logic          ae;
        logic          ovf;
        logic          udf;
        logic [DW-1:0] stdData;
        logic          fwftValid;
        logic [DW-1:0] fwftData;
    } expT;

    logic          clk;
    logic          rst_n;
    logic          clr;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          rd_en;
    logic [AW:0]   af_level;
    logic [AW:0]   ae_level;

    logic          sFull, sAf, sOvf, sEmpty, sAe, sUdf;
    logic [DW-1:0] sRdData;
    logic [AW:0]   sLevel;
    logic          fFull, fAf, fOvf, fEmpty, fAe, fUdf;
    logic [DW-1:0] fRdData;
    logic [AW:0]   fLevel;

    int testsRun    = 0;
    int testsFailed = 0;

    expT           expQ[$];
    logic [DW-1:0] mQ[$];
    logic [DW-1:0] mStdData = '0;
    logic          mReady   = 1'b0;
    logic [AW:0]   afReq    = 5'd12;
    logic [AW:0]   aeReq    = 5'd3;

    ipm_distributed_sync_fifo_v1_3 #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT_MODE(0)
    ) dutStd (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .wr_data(wr_data), .wr_en(wr_en),
        .full(sFull), .almost_full(sAf), .overflow(sOvf),
        .rd_data(sRdData), .rd_en(rd_en),
        .empty(sEmpty), .almost_empty(sAe), .underflow(sUdf),
        .af_level(af_level), .ae_level(ae_level), .water_level(sLevel)
    );

    ipm_distributed_sync_fifo_v1_3 #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT_MODE(1)
    ) dutFwft (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .wr_data(wr_data), .wr_en(wr_en),
        .full(fFull), .almost_full(fAf), .overflow(fOvf),
        .rd_data(fRdData), .rd_en(rd_en),
        .empty(fEmpty), .almost_empty(fAe), .underflow(fUdf),
        .af_level(af_level), .ae_level(ae_level), .water_level(fLevel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it and reports a FAIL line on mismatch.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Both instances must show the documented reset values.
    task automatic checkReset(input string tag);
        checkOutput({tag, ".std.empty"},  64'(sEmpty),  64'd1);
        checkOutput({tag, ".std.ae"},     64'(sAe),     64'd1);
        checkOutput({tag, ".std.full"},   64'(sFull),   64'd0);
        checkOutput({tag, ".std.af"},     64'(sAf),     64'd0);
        checkOutput({tag, ".std.ovf"},    64'(sOvf),    64'd0);
        checkOutput({tag, ".std.udf"},    64'(sUdf),    64'd0);
        checkOutput({tag, ".std.level"},  64'(sLevel),  64'd0);
        checkOutput({tag, ".std.data"},   64'(sRdData), 64'd0);
        checkOutput({tag, ".fwft.empty"}, 64'(fEmpty),  64'd1);
        checkOutput({tag, ".fwft.ae"},    64'(fAe),     64'd1);
        checkOutput({tag, ".fwft.full"},  64'(fFull),   64'd0);
        checkOutput({tag, ".fwft.af"},    64'(fAf),     64'd0);
        checkOutput({tag, ".fwft.ovf"},   64'(fOvf),    64'd0);
        checkOutput({tag, ".fwft.udf"},   64'(fUdf),    64'd0);
        checkOutput({tag, ".fwft.level"}, 64'(fLevel),  64'd0);
        checkOutput({tag, ".fwft.data"},  64'(fRdData), 64'd0);
    endtask

    // Drives one cycle of stimulus at the falling edge, steps the reference
    // model across the coming rising edge and queues the expected outputs.
    task automatic applyStimulus(input logic wr, input logic [DW-1:0] wd,
                                 input logic rd, input logic cl);
        expT  e;
        logic mFull, mEmpty, wrAcc, rdAcc;
        int   n;
        @(negedge clk);
        wr_en    = wr;
        wr_data  = wd;
        rd_en    = rd;
        clr      = cl;
        af_level = afReq;
        ae_level = aeReq;
        mFull  = (mQ.size() == DEPTH);
        mEmpty = (mQ.size() == 0);
        wrAcc  = wr && !mFull && !cl && mReady;
        rdAcc  = rd && !mEmpty && !cl;
        e.ovf  = wr && mFull && !cl;
        e.udf  = rd && mEmpty && !cl;
        if (cl) begin
            mQ.delete();
            mStdData = '0;
        end else begin
            if (rdAcc) mStdData = mQ.pop_front();
            if (wrAcc) mQ.push_back(wd);
        end
        mReady      = 1'b1;
        n           = mQ.size();
        e.level     = (AW + 1)'(n);
        e.full      = (n == DEPTH);
        e.empty     = (n == 0);
        e.af        = (e.level >= afReq);
        e.ae        = (e.level <= aeReq);
        e.stdData   = mStdData;
        e.fwftValid = (n != 0);
        e.fwftData  = (n != 0) ? mQ[0] : '0;
        expQ.push_back(e);
    endtask

    // Monitor: one expected entry per rising edge, sampled 1 ns after it.
    initial begin
        forever begin : monLoop
            expT e;
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("std.level", 64'(sLevel), 64'(e.level));
                checkOutput("std.full",  64'(sFull),  64'(e.full));
                checkOutput("std.empty", 64'(sEmpty), 64'(e.empty));
                checkOutput("std.af",    64'(sAf),    64'(e.af));
                checkOutput("std.ae",    64'(sAe),    64'(e.ae));
                checkOutput("std.ovf",   64'(sOvf),   64'(e.ovf));
                checkOutput("std.udf",   64'(sUdf),   64'(e.udf));
                checkOutput("std.data",  64'(sRdData), 64'(e.stdData));
                checkOutput("fwft.level", 64'(fLevel), 64'(e.level));
                checkOutput("fwft.full",  64'(fFull),  64'(e.full));
                checkOutput("fwft.empty", 64'(fEmpty), 64'(e.empty));
                checkOutput("fwft.af",    64'(fAf),    64'(e.af));
                checkOutput("fwft.ae",    64'(fAe),    64'(e.ae));
                checkOutput("fwft.ovf",   64'(fOvf),   64'(e.ovf));
                checkOutput("fwft.udf",   64'(fUdf),   64'(e.udf));
                if (e.fwftValid) begin
                    checkOutput("fwft.data", 64'(fRdData), 64'(e.fwftData));
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b1;
        clr      = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        wr_data  = '0;
        af_level = 5'd12;
        ae_level = 5'd3;
        #1 rst_n = 1'b0;
        #1 checkReset("por");
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // First edge after release never accepts a write.
        applyStimulus(1'b1, 32'hBEEF, 1'b0, 1'b0);

        // Fill 0..15; almost_full rises on the 12th write, almost_empty
        // falls on the 4th.
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);

        // Write while full: overflow pulse, contents untouched.
        applyStimulus(1'b1, 32'hDEAD, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);

        // Drain: 0..15 in order, then underflow with rd_data holding 15.
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);

        // Empty with write and read: write lands, read flagged as underflow.
        applyStimulus(1'b1, 32'h40, 1'b1, 1'b0);

        // Top up to full, then full with write and read: pop, write dropped.
        for (int i = 1; i < 16; i++) applyStimulus(1'b1, 32'h40 + 32'(i), 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h99, 1'b1, 1'b0);

        // Down to level 8, then 40 cycles of simultaneous traffic (wraps).
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0);

        // Level 10 with af_level=12, then lower the threshold to 8.
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h301, 1'b0, 1'b0);
        afReq = 5'd8;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        afReq = 5'd12;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);

        // Flush at level 7 with write and read requested.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hBAD, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);

        // Fall-through: 0xA5 visible right after its write edge, then popped.
        applyStimulus(1'b1, 32'hA5, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);

        // Burst interrupted by an asynchronous reset.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 checkReset("midburst");
        mQ.delete();
        mStdData = '0;
        mReady   = 1'b0;
        repeat (2) @(posedge clk);
        #1 checkReset("held");
        @(posedge clk);
        #3 rst_n = 1'b1;

        // 0x400 is offered on the first edge and dropped; 0x401 is accepted.
        applyStimulus(1'b1, 32'h400, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h401, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        checkOutput("scoreboard.drained", 64'(expQ.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
